grid_readout: RTL and testbench

GRID_READOUT -- requirements
Module: grid_readout

---
 rtl/grid_readout_pkg.sv | 32 +++
 rtl/grid_readout_if.sv | 37 +++
 rtl/grid_readout_cell_color_map.sv | 26 ++
 rtl/grid_readout.sv | 117 +++++++++++
 tb/tb_grid_readout.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_readout_pkg.sv
// Shared fixed-point constants, FSM state encoding and pixel payload for the grid readout path.
package grid_readout_pkg;

  localparam int unsigned FIX_W   = 18;
  localparam int unsigned FRAC_W  = 16;
  localparam int unsigned SUM_W   = FIX_W + 1;
  localparam int unsigned PIX_W   = 10;
  localparam int unsigned COLOR_W = 8;

  localparam logic [FIX_W-1:0] FIX_ONE = 18'h10000;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    EMIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0]   x;
    logic [PIX_W-1:0]   y;
    logic [COLOR_W-1:0] color;
    logic               frozen;
  } pix_t;

  // Index width that stays legal for a single-entry dimension.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grid_readout_if.sv
// Cell-memory read port and pixel-writer handshake between the grid readout and its neighbours.
interface grid_readout_if #(
  parameter int unsigned NUM_COLS = 8,
  parameter int unsigned NUM_ROWS = 11
);
  import grid_readout_pkg::*;

  localparam int unsigned COL_W = idx_w(NUM_COLS);
  localparam int unsigned ROW_W = idx_w(NUM_ROWS);

  logic [COL_W-1:0]   rd_col;
  logic [ROW_W-1:0]   rd_addr;
  logic [FIX_W-1:0]   rd_u;
  logic [FIX_W-1:0]   rd_v;

  logic [PIX_W-1:0]   pix_x;
  logic [PIX_W-1:0]   pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_frozen;
  logic               pix_valid;
  logic               pix_ready;

  modport master (
    output rd_col, rd_addr,
    input  rd_u, rd_v,
    output pix_x, pix_y, pix_color, pix_frozen, pix_valid,
    input  pix_ready
  );

  modport slave (
    input  rd_col, rd_addr,
    output rd_u, rd_v,
    input  pix_x, pix_y, pix_color, pix_frozen, pix_valid,
    output pix_ready
  );

endinterface

// File: rtl/grid_readout_cell_color_map.sv
// Maps a cell's (u, v) state to its frozen flag and grey level; purely combinational.
module cell_color_map
  import grid_readout_pkg::*;
(
  input  logic [FIX_W-1:0]   u,
  input  logic [FIX_W-1:0]   v,
  output logic               frozen_c,
  output logic [COLOR_W-1:0] color_c
);

  logic signed [SUM_W-1:0] sum;

  // One guard bit keeps the 2.16 sum from wrapping.
  always_comb begin
    sum      = $signed({u[FIX_W-1], u}) + $signed({v[FIX_W-1], v});
    frozen_c = (sum >= $signed({1'b0, FIX_ONE}));
    if (frozen_c) begin
      color_c = 8'hFF;
    end else if (sum[SUM_W-1]) begin
      color_c = 8'h00;
    end else begin
      color_c = sum[FRAC_W-1 -: COLOR_W];
    end
  end

endmodule

// File: rtl/grid_readout.sv
// Column-major scan of the cell grid: reads each cell, maps it to a grey pixel, hands it to the writer.
module grid_readout
  import grid_readout_pkg::*;
#(
  parameter int unsigned NUM_COLS = 8,
  parameter int unsigned NUM_ROWS = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic           busy,
  output logic           done,
  grid_readout_if.master bus
);

  localparam int unsigned COL_W = idx_w(NUM_COLS);
  localparam int unsigned ROW_W = idx_w(NUM_ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);

  state_t             state_q, state_next;
  logic [COL_W-1:0]   col_q, col_next;
  logic [ROW_W-1:0]   row_q, row_next;
  logic               load_pix;
  pix_t               pix_q;
  logic               pix_valid_q;
  logic               frozen_c;
  logic [COLOR_W-1:0] color_c;

  cell_color_map u_color_map (
    .u        (bus.rd_u),
    .v        (bus.rd_v),
    .frozen_c (frozen_c),
    .color_c  (color_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next state and scan position; row advances fastest.
  always_comb begin
    state_next = state_q;
    col_next   = col_q;
    row_next   = row_q;
    load_pix   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_next = ADDR;
          col_next   = '0;
          row_next   = '0;
        end
      end
      ADDR: state_next = WAIT;
      WAIT: begin
        state_next = EMIT;
        load_pix   = 1'b1;
      end
      EMIT: begin
        if (bus.pix_ready) begin
          state_next = ADDR;
          if (row_q == ROW_LAST) begin
            row_next = '0;
            if (col_q == COL_LAST) begin
              col_next   = '0;
              state_next = DONE;
            end else begin
              col_next = col_q + COL_W'(1);
            end
          end else begin
            row_next = row_q + ROW_W'(1);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pixel fields latch once per cell, in the cycle the read data is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      col_q       <= col_next;
      row_q       <= row_next;
      pix_valid_q <= (state_next == EMIT);
      busy        <= (state_next == ADDR) || (state_next == WAIT) || (state_next == EMIT);
      done        <= (state_next == DONE);
      if (load_pix) begin
        pix_q.x      <= PIX_W'(col_q);
        pix_q.y      <= PIX_W'({row_q, col_q[0]});
        pix_q.color  <= color_c;
        pix_q.frozen <= frozen_c;
      end
    end
  end

  assign bus.rd_col     = col_q;
  assign bus.rd_addr    = row_q;
  assign bus.pix_x      = pix_q.x;
  assign bus.pix_y      = pix_q.y;
  assign bus.pix_color  = pix_q.color;
  assign bus.pix_frozen = pix_q.frozen;
  assign bus.pix_valid  = pix_valid_q;

endmodule

// File: tb/tb_grid_readout.sv
// Scoreboard bench for grid_readout: random cell memory, random/stalled ready, reset and start abuse.
`timescale 1ns/1ps
module tb_grid_readout;
  import grid_readout_pkg::*;

  localparam int unsigned NC     = 2;
  localparam int unsigned NR     = 3;
  localparam int unsigned NCELLS = NC * NR;

  typedef struct {
    int x;
    int y;
    int color;
    int frozen;
    bit first;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;

  grid_readout_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) bus ();

  grid_readout #(.NUM_COLS(NC), .NUM_ROWS(NR)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [17:0] mem_u [NC][NR];
  logic [17:0] mem_v [NC][NR];

  // Cell memory with one cycle of read latency.
  always @(posedge clk) begin
    bus.rd_u <= mem_u[bus.rd_col][bus.rd_addr];
    bus.rd_v <= mem_v[bus.rd_col][bus.rd_addr];
  end

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference pixel: plain integer arithmetic on the 2.16 values.
  function automatic exp_t ref_pix(input int c, input int r, input bit first, input bit last);
    exp_t e;
    int   a;
    int   b;
    int   s;
    a = $signed(mem_u[c][r]);
    b = $signed(mem_v[c][r]);
    s = a + b;
    e.x      = c;
    e.y      = 2 * r + (c % 2);
    e.frozen = (s >= 65536) ? 1 : 0;
    e.color  = (s >= 65536) ? 255 : ((s < 0) ? 0 : (s / 256));
    e.first  = first;
    e.last   = last;
    return e;
  endfunction

  // Monitor: compare any presented pixel with the scoreboard head; pop on handshake.
  int   cyc = 0;
  int   scan_hs = 0;
  int   last_hs_cyc = 0;
  int   scans_done = 0;
  bit   pend_done = 1'b0;
  bit   check_spacing = 1'b0;
  exp_t mon_e;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pend_done = 1'b0;
      scan_hs   = 0;
    end else begin
      check("done_pulse", int'(done), int'(pend_done));
      if (pend_done) scans_done++;
      pend_done = 1'b0;
      if (bus.pix_valid) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel x=%0d y=%0d with empty scoreboard at %0t",
                   bus.pix_x, bus.pix_y, $time);
        end else begin
          mon_e = sb[0];
          check("pix_x", int'(bus.pix_x), mon_e.x);
          check("pix_y", int'(bus.pix_y), mon_e.y);
          check("pix_color", int'(bus.pix_color), mon_e.color);
          check("pix_frozen", int'(bus.pix_frozen), mon_e.frozen);
          if (bus.pix_ready) begin
            void'(sb.pop_front());
            if (check_spacing && !mon_e.first) check("hs_spacing", cyc - last_hs_cyc, 3);
            last_hs_cyc = cyc;
            scan_hs++;
            if (mon_e.last) begin
              check("scan_hs_count", scan_hs, NCELLS);
              scan_hs   = 0;
              pend_done = 1'b1;
            end
          end
        end
      end
    end
  end

  // Ready driver: 0 = tied high, 1 = random with one 10-cycle stall on cell 2, 3 = only first 3 cells.
  int ready_mode = 0;
  int stall_left = 0;
  bit stall_used = 1'b1;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1 && !stall_used && scan_hs == 2 && bus.pix_valid) begin
      stall_used = 1'b1;
      stall_left = 10;
    end
    if (stall_left > 0) begin
      bus.pix_ready = 1'b0;
      stall_left--;
    end else if (ready_mode == 0) begin
      bus.pix_ready = 1'b1;
    end else if (ready_mode == 1) begin
      bus.pix_ready = 1'($urandom_range(0, 1));
    end else begin
      bus.pix_ready = (scan_hs < 3);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill_mem();
    logic [17:0] u;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        u = 18'($urandom);
        mem_u[c][r] = u;
        case ($urandom_range(0, 2))
          0:       mem_v[c][r] = 18'($urandom);
          1:       mem_v[c][r] = 18'(65536 - int'($signed(u)) + int'($urandom_range(0, 4)) - 2);
          default: mem_v[c][r] = 18'($urandom_range(0, 65535));
        endcase
      end
    end
  endtask

  task automatic start_scan();
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        sb.push_back(ref_pix(c, r, (c == 0 && r == 0), (c == NC - 1 && r == NR - 1)));
      end
    end
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_scan(input int target);
    int n = 0;
    while (scans_done < target && n < 2000) begin
      tick(1);
      n++;
    end
    check("scan_complete", int'(scans_done >= target), 1);
    tick(2);
    check("busy_after_scan", int'(busy), 0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    fill_mem();
    tick(3);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pix_valid", int'(bus.pix_valid), 0);
    check("rst_pix_x", int'(bus.pix_x), 0);
    check("rst_pix_y", int'(bus.pix_y), 0);
    check("rst_pix_color", int'(bus.pix_color), 0);
    check("rst_pix_frozen", int'(bus.pix_frozen), 0);
    check("rst_rd_col", int'(bus.rd_col), 0);
    check("rst_rd_addr", int'(bus.rd_addr), 0);
    reset = 1'b0;
    tick(2);

    // Ready tied high: exact order, 3-cycle spacing, directed color corners.
    mem_u[0][0] = 18'h04000; mem_v[0][0] = 18'h0C000;
    mem_u[0][1] = 18'h04000; mem_v[0][1] = 18'h00000;
    mem_u[0][2] = 18'h3C000; mem_v[0][2] = 18'h00000;
    ready_mode    = 0;
    check_spacing = 1'b1;
    start_scan();
    check("busy_after_start", int'(busy), 1);
    wait_scan(1);
    check_spacing = 1'b0;

    // Random ready with a long stall on cell 2.
    fill_mem();
    ready_mode = 1;
    stall_used = 1'b0;
    start_scan();
    wait_scan(2);

    // Start pulses during a scan are ignored.
    fill_mem();
    start_scan();
    tick(7);
    start = 1'b1; tick(1); start = 1'b0;
    tick(5);
    start = 1'b1; tick(1); start = 1'b0;
    wait_scan(3);

    // Reset while cell 3 is held in EMIT aborts the scan.
    fill_mem();
    ready_mode = 3;
    start_scan();
    n = 0;
    while (!(scan_hs == 3 && bus.pix_valid) && n < 200) begin
      tick(1);
      n++;
    end
    check("reach_cell3", int'(scan_hs == 3 && bus.pix_valid), 1);
    reset = 1'b1;
    sb.delete();
    tick(1);
    check("abort_pix_valid", int'(bus.pix_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    reset = 1'b0;
    tick(4);
    check("abort_idle_busy", int'(busy), 0);
    fill_mem();
    ready_mode = 1;
    start_scan();
    wait_scan(4);

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    tick(1);
    reset = 1'b0;
    start = 1'b0;
    tick(3);
    check("rst_over_start_busy", int'(busy), 0);
    check("rst_over_start_valid", int'(bus.pix_valid), 0);

    // A few more random scans.
    for (int i = 0; i < 3; i++) begin
      fill_mem();
      ready_mode = (i == 1) ? 0 : 1;
      start_scan();
      wait_scan(5 + i);
    end

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
